decoder_429: RTL and testbench

- ARINC-429 line receiver and decoder. It sits directly downstream of the transmit path's Encoder_429 and consumes its encodedOutput_A/encodedOutput_B pair.
- Samples the bipolar RZ line, recovers bits, frames 32-bit words on inter-word gaps, checks odd parity and presents each word to a host through a ready/ack holding register.
- Used for loopback self-test and for the receive channel.

---
 rtl/decoder_429.sv | 249 ++++++++++++++++++++++++
 tb/tb_decoder_429.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_429.sv
// ARINC-429 line receiver/decoder.
// Samples the bipolar RZ pair (rx_a/rx_b), recovers bits, frames 32-bit words
// on inter-word gaps, checks odd parity and holds each word for the host
// behind a data_ready/rd_ack handshake.
//
// Ports:
//   clk, clr                 clock, asynchronous active-low reset
//   rx_a, rx_b               line pair, asynchronous to clk
//   speed                    1 = high speed, 0 = low speed (latched between words)
//   rd_ack                   host pulse consuming the held word
//   data_out[31:0]           last received word, first bit in bit 31
//   data_ready               a word is held and not yet acknowledged
//   data_valid               one-cycle strobe when data_out updates
//   parity_err               data_out has an even number of ones
//   frame_err                one-cycle strobe on a framing violation
//   overrun                  sticky; a word arrived while data_ready was set
//
// Optional build macro LABEL_FILTER_EN adds label_match[7:0] and label_filt;
// with label_filt=1 a word whose label byte [31:24] differs from label_match
// is dropped without any host-visible effect.
module decoder_429 #(
    parameter int unsigned HI_BIT_CYC = 500,
    parameter int unsigned LO_BIT_CYC = 4000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        rx_a,
    input  logic        rx_b,
    input  logic        speed,
    input  logic        rd_ack,
`ifdef LABEL_FILTER_EN
    input  logic [7:0]  label_match,
    input  logic        label_filt,
`endif
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        data_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun
);

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned BCNT_W    = 6;

    typedef enum logic [1:0] {
        SYM_NULL = 2'b00,
        SYM_ZERO = 2'b01,
        SYM_ONE  = 2'b10,
        SYM_ILL  = 2'b11
    } sym_t;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_PULSE,
        ST_BITNULL
    } state_t;

    logic [1:0]       a_sync, b_sync;
    sym_t             sym_c;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] null_cnt, null_nxt;
    logic [CNT_W-1:0] pulse_cnt, pulse_nxt;
    logic [CNT_W-1:0] bit_cyc, bit_cyc_nxt;
    logic [BCNT_W-1:0] bit_cnt, bit_nxt;
    logic [WORD_BITS-1:0] shreg, shreg_nxt;
    logic             pol, pol_nxt;
    logic             word_done_c;
    logic             ferr_c;
    logic             deliver_c;
    logic             filter_pass_c;

    logic [CNT_W-1:0] null_inc_c, pulse_inc_c;
    logic [CNT_W-1:0] minp_c, maxp_c, gap_c;
    logic [CNT_W-1:0] speed_cyc_c;
    logic             gap_hit_c;

    // Two-flop synchronizers on each line
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[0], rx_a};
            b_sync <= {b_sync[0], rx_b};
        end
    end

    assign sym_c = sym_t'({a_sync[1], b_sync[1]});

    // Bit timing thresholds derived from the latched bit period
    assign speed_cyc_c = speed ? CNT_W'(HI_BIT_CYC) : CNT_W'(LO_BIT_CYC);
    assign minp_c      = bit_cyc >> 2;
    assign maxp_c      = bit_cyc - (bit_cyc >> 2);
    assign gap_c       = bit_cyc << 1;
    assign null_inc_c  = null_cnt + CNT_W'(1);
    assign pulse_inc_c = pulse_cnt + CNT_W'(1);
    // >= so a stale null count (e.g. after a glitch from IDLE) still terminates
    assign gap_hit_c   = (null_inc_c >= gap_c);

    // State and datapath registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= ST_SYNC;
            null_cnt  <= '0;
            pulse_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            pol       <= 1'b0;
            bit_cyc   <= CNT_W'(LO_BIT_CYC);
        end else begin
            state     <= state_nxt;
            null_cnt  <= null_nxt;
            pulse_cnt <= pulse_nxt;
            bit_cnt   <= bit_nxt;
            shreg     <= shreg_nxt;
            pol       <= pol_nxt;
            bit_cyc   <= bit_cyc_nxt;
        end
    end

    // Next-state and framing decisions
    always_comb begin
        state_nxt   = state;
        null_nxt    = null_cnt;
        pulse_nxt   = pulse_cnt;
        bit_nxt     = bit_cnt;
        shreg_nxt   = shreg;
        pol_nxt     = pol;
        bit_cyc_nxt = bit_cyc;
        word_done_c = 1'b0;
        ferr_c      = 1'b0;

        case (state)
            ST_SYNC: begin
                bit_cyc_nxt = speed_cyc_c;
                if (sym_c == SYM_NULL) begin
                    null_nxt = null_inc_c;
                    if (gap_hit_c) begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    null_nxt = '0;
                end
            end

            ST_IDLE: begin
                bit_cyc_nxt = speed_cyc_c;
                bit_nxt     = '0;
                if (sym_c == SYM_ONE || sym_c == SYM_ZERO) begin
                    pol_nxt   = (sym_c == SYM_ONE);
                    pulse_nxt = CNT_W'(1);
                    state_nxt = ST_PULSE;
                end else if (sym_c == SYM_ILL) begin
                    ferr_c    = 1'b1;
                    null_nxt  = '0;
                    state_nxt = ST_SYNC;
                end
            end

            ST_PULSE: begin
                if ((sym_c == SYM_ONE && pol) || (sym_c == SYM_ZERO && !pol)) begin
                    pulse_nxt = pulse_inc_c;
                    if (pulse_inc_c > maxp_c) begin
                        ferr_c    = 1'b1;
                        null_nxt  = '0;
                        state_nxt = ST_SYNC;
                    end
                end else if (sym_c == SYM_NULL) begin
                    // Pulses shorter than a quarter bit are glitches and not shifted
                    if (pulse_cnt >= minp_c) begin
                        shreg_nxt = {shreg[WORD_BITS-2:0], pol};
                        bit_nxt   = bit_cnt + BCNT_W'(1);
                        null_nxt  = CNT_W'(1);
                    end
                    state_nxt = ST_BITNULL;
                end else begin
                    ferr_c    = 1'b1;
                    null_nxt  = '0;
                    state_nxt = ST_SYNC;
                end
            end

            ST_BITNULL: begin
                if (sym_c == SYM_NULL) begin
                    null_nxt = null_inc_c;
                    if (gap_hit_c) begin
                        state_nxt = ST_IDLE;
                        if (bit_cnt == BCNT_W'(WORD_BITS)) begin
                            word_done_c = 1'b1;
                        end else if (bit_cnt != '0) begin
                            ferr_c = 1'b1;
                        end
                    end
                end else if (sym_c == SYM_ILL || bit_cnt == BCNT_W'(WORD_BITS)) begin
                    ferr_c    = 1'b1;
                    null_nxt  = '0;
                    state_nxt = ST_SYNC;
                end else begin
                    pol_nxt   = (sym_c == SYM_ONE);
                    pulse_nxt = CNT_W'(1);
                    state_nxt = ST_PULSE;
                end
            end

            default: begin
                null_nxt  = '0;
                state_nxt = ST_SYNC;
            end
        endcase
    end

`ifdef LABEL_FILTER_EN
    assign filter_pass_c = !label_filt || (shreg[31:24] == label_match);
`else
    assign filter_pass_c = 1'b1;
`endif

    assign deliver_c = word_done_c && filter_pass_c;

    // Host-facing holding register and status
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data_out   <= '0;
            parity_err <= 1'b0;
            data_valid <= 1'b0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= deliver_c;
            frame_err  <= ferr_c;
            if (deliver_c) begin
                data_out   <= shreg;
                parity_err <= ~^shreg;
                data_ready <= 1'b1;
                // A coincident ack consumes the old word, so no overrun then
                overrun    <= rd_ack ? 1'b0 : (overrun | data_ready);
            end else if (rd_ack) begin
                data_ready <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decoder_429.sv
// Self-checking bench for decoder_429: RZ line stimulus, a word-level
// expectation queue and a per-cycle output comparator.
module tb_decoder_429;

    localparam int unsigned HI = 40;
    localparam int unsigned LO = 160;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        rx_a = 1'b0;
    logic        rx_b = 1'b0;
    logic        speed = 1'b1;
    logic        rd_ack = 1'b0;
    logic [31:0] data_out;
    logic        data_ready, data_valid, parity_err, frame_err, overrun;
`ifdef LABEL_FILTER_EN
    logic [7:0]  label_match = 8'h00;
    logic        label_filt = 1'b0;
`endif

    decoder_429 #(.HI_BIT_CYC(HI), .LO_BIT_CYC(LO), .CNT_W(16)) dut (
        .clk        (clk),
        .clr        (clr),
        .rx_a       (rx_a),
        .rx_b       (rx_b),
        .speed      (speed),
        .rd_ack     (rd_ack),
`ifdef LABEL_FILTER_EN
        .label_match(label_match),
        .label_filt (label_filt),
`endif
        .data_out   (data_out),
        .data_ready (data_ready),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic ack_q = 1'b0;
    always @(posedge clk) ack_q <= rd_ack;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        bit          frame;
        logic [31:0] data;
    } ev_t;

    ev_t evq[$];

    logic [31:0] exp_data = '0;
    bit exp_par = 0, exp_ready = 0, exp_ovr = 0;
    bit exp_dv, exp_fe, got_deliver;
    ev_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h want %h", name, cyc, act, req);
        end
    endtask

    task automatic push_ev(input int c, input bit f, input logic [31:0] d);
        ev_t e;
        e.cyc = c;
        e.frame = f;
        e.data = d;
        evq.push_back(e);
    endtask

    function automatic int bit_len();
        return speed ? int'(HI) : int'(LO);
    endfunction

    function automatic bit keep(input logic [31:0] w);
`ifdef LABEL_FILTER_EN
        return !label_filt || (w[31:24] == label_match);
`else
        return (w == w);
`endif
    endfunction

    // Per-cycle comparison against the word-level expectation
    always @(negedge clk) begin
        exp_dv = 0;
        exp_fe = 0;
        got_deliver = 0;
        if (evq.size() != 0 && evq[0].cyc == cyc) begin
            cur = evq.pop_front();
            if (cur.frame) begin
                exp_fe = 1;
            end else begin
                exp_dv = 1;
                got_deliver = 1;
                exp_data = cur.data;
                exp_par = ($countones(cur.data) % 2 == 0);
            end
        end
        if (got_deliver) begin
            exp_ovr = ack_q ? 1'b0 : (exp_ovr | exp_ready);
            exp_ready = 1;
        end else if (ack_q) begin
            exp_ready = 0;
            exp_ovr = 0;
        end
        chk("data_valid", 32'(data_valid), 32'(exp_dv));
        chk("frame_err", 32'(frame_err), 32'(exp_fe));
        chk("data_ready", 32'(data_ready), 32'(exp_ready));
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        chk("data_out", data_out, exp_data);
        chk("parity_err", 32'(parity_err), 32'(exp_par));
        if (evq.size() != 0 && evq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event at cyc %0d: expected at %0d", cyc, evq[0].cyc);
            void'(evq.pop_front());
        end
    end

    task automatic drive(input logic a, input logic b, input int n);
        rx_a = a;
        rx_b = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic null_gap(input int n, input int ack_at);
        rx_a = 1'b0;
        rx_b = 1'b0;
        for (int j = 0; j < n; j++) begin
            rd_ack = (j == ack_at);
            @(negedge clk);
        end
        rd_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_speed(input logic s);
        speed = s;
        null_gap(2 * LO + 20, -1);
    endtask

    // tail: 0 = gap ends the word, 1 = extra pulse before the gap,
    //       2 = illegal A=B=1, 3 = pulse held past the maximum width
    task automatic send_word(input logic [31:0] w, input int nbits, input int tail,
                             input int glitch_bit, input int ack_at, input bit jitter);
        int b, half, gap, hw, lw, k, maxp;
        logic v;
        b = bit_len();
        half = b / 2;
        gap = 2 * b;
        maxp = b - b / 4;
        for (int i = 0; i < nbits; i++) begin
            v = w[31-i];
            hw = half + (jitter ? int'($urandom_range(4)) - 2 : 0);
            lw = half + (jitter ? int'($urandom_range(4)) - 2 : 0);
            drive(v, ~v, hw);
            k = cyc;
            if (i == nbits - 1 && tail == 0) begin
                if (nbits == 32) begin
                    if (keep(w)) push_ev(k + gap + 2, 1'b0, w);
                end else begin
                    push_ev(k + gap + 2, 1'b1, '0);
                end
                null_gap(gap + 20, ack_at);
            end else if (i == glitch_bit) begin
                drive(1'b0, 1'b0, lw / 2 - 5);
                drive(1'b1, 1'b0, 10);
                drive(1'b0, 1'b0, lw - lw / 2 - 5);
            end else begin
                drive(1'b0, 1'b0, lw);
            end
        end
        if (tail != 0) begin
            k = cyc;
            if (tail == 3) begin
                push_ev(k + maxp + 3, 1'b1, '0);
                drive(1'b1, 1'b0, maxp + 5);
            end else begin
                push_ev(k + 3, 1'b1, '0);
                drive(1'b1, (tail == 2), half);
            end
            null_gap(gap + 20, -1);
        end
    endtask

    initial begin
        int kind, ack_at, nb, g;
        logic [31:0] w;
        repeat (3) @(negedge clk);
        chk("reset_data_out", data_out, 32'h0);
        chk("reset_ready", 32'(data_ready), 32'h0);
        chk("reset_valid", 32'(data_valid), 32'h0);
        clr = 1'b1;
        null_gap(2 * LO + 20, -1);

        send_word(32'h000000A1, 32, 0, -1, -1, 0);
        chk("w1_data", data_out, 32'h000000A1);
        chk("w1_parity", 32'(parity_err), 32'h0);
        chk("w1_ready", 32'(data_ready), 32'h1);

        send_word(32'h000000A0, 32, 0, -1, -1, 0);
        chk("w2_parity", 32'(parity_err), 32'h1);
        ack_pulse();
        chk("w2_ack_ready", 32'(data_ready), 32'h0);

        send_word(32'h12345679, 32, 0, -1, -1, 0);
        send_word(32'h0F0F0F0E, 32, 0, -1, -1, 0);
        chk("ovr_data", data_out, 32'h0F0F0F0E);
        chk("ovr_flag", 32'(overrun), 32'h1);
        ack_pulse();
        chk("ovr_clear", 32'(overrun), 32'h0);
        chk("ovr_ready", 32'(data_ready), 32'h0);

        send_word(32'hDEADBEEF, 20, 0, -1, -1, 0);
        chk("short_ready", 32'(data_ready), 32'h0);
        send_word(32'hCAFEF00D, 32, 1, -1, -1, 0);
        send_word(32'h5555AAAA, 32, 0, -1, -1, 0);
        chk("after_err_data", data_out, 32'h5555AAAA);
        chk("after_err_par", 32'(parity_err), 32'h1);
        send_word(32'hA0000000, 3, 3, -1, -1, 0);

        set_speed(1'b0);
        send_word(32'hC0000001, 32, 0, 5, -1, 0);
        chk("glitch_data", data_out, 32'hC0000001);
        send_word(32'h12345678, 10, 2, -1, -1, 0);
        ack_pulse();

`ifdef LABEL_FILTER_EN
        label_filt = 1'b1;
        label_match = 8'hC0;
        send_word(32'hC0000001, 32, 0, -1, -1, 0);
        chk("filt_pass", data_out, 32'hC0000001);
        send_word(32'h81000000, 32, 0, -1, -1, 0);
        chk("filt_drop", data_out, 32'hC0000001);
        label_filt = 1'b0;
        ack_pulse();
`endif

        set_speed(1'b1);
        for (int it = 0; it < 22; it++) begin
            if ($urandom_range(5) == 0) set_speed(~speed);
            w = $urandom;
            kind = int'($urandom_range(9));
            g = 2 * bit_len();
            case ($urandom_range(2))
                0: ack_at = -1;
                1: ack_at = g + 1;
                default: ack_at = int'($urandom_range(g + 19));
            endcase
            if (kind == 0) begin
                nb = int'($urandom_range(31, 1));
                send_word(w, nb, 0, -1, ack_at, 1);
            end else if (kind == 1) begin
                send_word(w, 32, 1, -1, -1, 1);
            end else begin
                send_word(w, 32, 0, -1, ack_at, 1);
            end
        end

        repeat (4) @(negedge clk);
        chk("events_left", 32'(evq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
